// File: rtl/serial_subtractor5_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor5_pkg;

    localparam int SUB_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_subtractor5_pkg

// File: rtl/serial_subtractor5_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// The master issues operations; the slave (the subtractor) returns results.
interface serial_subtractor5_if #(
    parameter int WIDTH = serial_subtractor5_pkg::SUB_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_borrow;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_d;
    logic             out_borrow;
    logic             out_zero;

    modport master (
        output start, in_a, in_b, in_borrow,
        input  busy, done, out_d, out_borrow, out_zero
    );

    modport slave (
        input  start, in_a, in_b, in_borrow,
        output busy, done, out_d, out_borrow, out_zero
    );
endinterface : serial_subtractor5_if

// File: rtl/serial_subtractor5_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Gate-level mirror of the team's fullAdder cell.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic aXorB;

    assign aXorB = a ^ b;
    assign d     = aXorB ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout  = (~a & b) | (~aXorB & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor5.sv
// Bit-serial subtractor: one full-subtractor cell processes in_a - in_b - in_borrow
// LSB first, one bit per clock, behind a start/busy/done handshake.
module serial_subtractor5
    import serial_subtractor5_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    serial_subtractor5_if.slave   bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] aSh_q,       aSh_d;
    logic [WIDTH-1:0] bSh_q,       bSh_d;
    logic [WIDTH-1:0] resSh_q,     resSh_d;
    logic             borrow_q,    borrow_d;
    logic [WIDTH-1:0] outD_q,      outD_d;
    logic             outBorrow_q, outBorrow_d;
    logic             outZero_q,   outZero_d;

    logic             cellD;
    logic             cellBout;
    logic [WIDTH-1:0] resNext;

    full_subtractor uCell (
        .a    (aSh_q[0]),
        .b    (bSh_q[0]),
        .bin  (borrow_q),
        .d    (cellD),
        .bout (cellBout)
    );

    // Result register after this edge's bit has been shifted in at the MSB.
    assign resNext = {cellD, resSh_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            aSh_q       <= '0;
            bSh_q       <= '0;
            resSh_q     <= '0;
            borrow_q    <= 1'b0;
            outD_q      <= '0;
            outBorrow_q <= 1'b0;
            outZero_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            aSh_q       <= aSh_d;
            bSh_q       <= bSh_d;
            resSh_q     <= resSh_d;
            borrow_q    <= borrow_d;
            outD_q      <= outD_d;
            outBorrow_q <= outBorrow_d;
            outZero_q   <= outZero_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        aSh_d       = aSh_q;
        bSh_d       = bSh_q;
        resSh_d     = resSh_q;
        borrow_d    = borrow_q;
        outD_d      = outD_q;
        outBorrow_d = outBorrow_q;
        outZero_d   = outZero_q;

        unique case (state_q)
            IDLE, DONE: begin
                // A DONE cycle accepts a new request directly, giving full throughput.
                if (bus.start) begin
                    aSh_d    = bus.in_a;
                    bSh_d    = bus.in_b;
                    borrow_d = bus.in_borrow;
                    resSh_d  = '0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end

            SHIFT: begin
                aSh_d    = aSh_q >> 1;
                bSh_d    = bSh_q >> 1;
                resSh_d  = resNext;
                borrow_d = cellBout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    outD_d      = resNext;
                    outBorrow_d = cellBout;
                    outZero_d   = (resNext == '0);
                    state_d     = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy       = (state_q == SHIFT);
    assign bus.done       = (state_q == DONE);
    assign bus.out_d      = outD_q;
    assign bus.out_borrow = outBorrow_q;
    assign bus.out_zero   = outZero_q;

endmodule : serial_subtractor5
